sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 12000, meaning the count of consecutive stable cycles required to accept a new sensor level (1 ms at 12 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the debounce counter width; it SHALL be at least clog2(DEBOUNCE_CYCLES).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic SHALL be in this one clock domain.
REQ-004 The block SHALL have port rst, input, 1; reset SHALL be synchronous and active-high.
REQ-005 The block SHALL have port a_raw, input, 1, the asynchronous outer photo-sensor, idle high and low while a car blocks the beam.
REQ-006 The block SHALL have port b_raw, input, 1, the asynchronous inner photo-sensor, idle high and low while blocked.
REQ-007 The block SHALL have port a, output, 1, the debounced level of a_raw, which feeds the parking-lot counter stage directly.
REQ-008 The block SHALL have port b, output, 1, the debounced level of b_raw.
REQ-009 The block SHALL have ports a_fall, a_rise, b_fall and b_rise, each an output of width 1, carrying a one-cycle pulse on each accepted edge of a or b.

Function
REQ-010 Each channel SHALL pass its raw input through a two-flop synchronizer whose output is sync; both flops SHALL reset to 1.
REQ-011 While sync equals the clean output, the channel counter SHALL be 0.
REQ-012 While sync differs from the clean output, the counter SHALL increment by 1 each cycle.
REQ-013 On the cycle in which the counter equals DEBOUNCE_CYCLES-1 and sync still differs, the channel SHALL, at the next edge:
- load clean with sync,
- clear the counter,
- assert the matching rise or fall pulse.
REQ-014 If sync returns to the clean level before the threshold, the counter SHALL clear on the next edge, with no output change and no pulse (glitch rejection).
REQ-015 A raw level held stable from edge k onward SHALL appear on the clean output at edge k+DEBOUNCE_CYCLES+2, so total latency is DEBOUNCE_CYCLES+2 cycles.
REQ-016 Each pulse SHALL be registered, high for exactly one cycle, and coincident with the first cycle of the new clean level.
REQ-017 fall and rise pulses of the same channel SHALL never be high in the same cycle.
REQ-018 Channels a and b SHALL be fully independent; simultaneous changes on both SHALL yield pulses on both channels in the same cycle.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While rst is high, the outputs SHALL be a=1 and b=1, with a_fall, a_rise, b_fall and b_rise all 0.
REQ-021 While rst is high, the synchronizer flops SHALL be 1 and the counters SHALL be 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted in the cycle after rst deasserts.
REQ-023 If a raw input is low at reset release, it SHALL be treated as a new edge: a fall pulse SHALL appear DEBOUNCE_CYCLES+2 cycles after release.

Structure
REQ-024 The default DEBOUNCE_CYCLES value and the sensor idle level (1) SHALL live in the shared package parking_pkg, also used by parking_lot.
REQ-025 The per-channel synchronizer, counter, clean register and edge pulses SHALL be one sub-module, debounce_channel, instantiated twice.
REQ-026 The block SHALL be fully synchronous, with no latches and no combinational path from input to output.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset: hold rst for 3 cycles with a_raw=0 -> a=1, b=1, all pulses 0 during reset; a_fall pulses exactly 6 cycles after release.
REQ-028 Clean edge: drive a_raw 1->0 and hold for 10 cycles -> a falls 6 cycles after the change, and a_fall is high for exactly 1 cycle in that same cycle.
REQ-029 Glitch: drive b_raw low for 3 cycles, then high -> b stays 1 and no pulses occur.
REQ-030 Simultaneous: drive a_raw and b_raw low on the same edge -> a_fall and b_fall pulse in the same cycle.
REQ-031 Reset mid-count: assert rst 2 cycles after a_raw falls -> counter is 0, a=1, and the fall is accepted 6 cycles after release.
REQ-032 Car sequence: a_raw, b_raw, a_raw and b_raw change at 10-cycle spacing (a low, b low, a high, b high) -> a_fall, b_fall, a_rise, b_rise occur in that order, 10 cycles apart.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants and types for the parking-lot sensor path.
// Used by sensor_conditioner and parking_lot.
package parking_pkg;

  localparam int   DEBOUNCE_DEFAULT = 12000;
  localparam int   CNT_W_DEFAULT    = 16;
  localparam logic SENSOR_IDLE      = 1'b1;

  typedef struct packed {
    logic fall;
    logic rise;
  } edge_t;

  function automatic edge_t edge_of(
    input logic hit,
    input logic lvl
  );
    edge_t e;
    e.fall = hit & ~lvl;
    e.rise = hit & lvl;
    return e;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: two-flop synchronizer, stability counter,
// clean level register and registered edge pulses.
module debounce_channel
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             hit;
  edge_t            nxt_edge;

  // Bring the asynchronous sensor into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= SENSOR_IDLE;
      sync <= SENSOR_IDLE;
    end else begin
      s1   <= raw;
      sync <= s1;
    end
  end

  // Accept the new level only once it has been stable long enough.
  always_comb begin
    diff     = sync != level;
    hit      = diff && (cnt == LAST);
    nxt_edge = edge_of(hit, sync);
  end

  // Counter runs only while sync disagrees; clears on accept or glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!diff || hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Clean level and one-cycle edge pulses, aligned with each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= SENSOR_IDLE;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      if (hit) level <= sync;
      fall <= nxt_edge.fall;
      rise <= nxt_edge.rise;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the outer (a) and inner (b) photo-sensors
// for the parking-lot counter; channels are independent.
module sensor_conditioner
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_fall,
  output logic a_rise,
  output logic b_fall,
  output logic b_rise
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (a_raw),
    .level(a),
    .fall (a_fall),
    .rise (a_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (b_raw),
    .level(b),
    .fall (b_fall),
    .rise (b_rise)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4.
// Expected pulses are queued with their due cycle.
module tb_sensor_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic rst;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_fall;
  logic a_rise;
  logic b_fall;
  logic b_rise;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [3:0] p;
  } exp_t;

  exp_t q[$];

  localparam logic [3:0] AF = 4'b1000;
  localparam logic [3:0] AR = 4'b0100;
  localparam logic [3:0] BF = 4'b0010;
  localparam logic [3:0] BR = 4'b0001;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .a_fall(a_fall),
    .a_rise(a_rise),
    .b_fall(b_fall),
    .b_rise(b_rise)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int due, input logic [3:0] p);
    exp_t e;
    e.due = due;
    e.p   = p;
    q.push_back(e);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the queue head.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t       e;
    if (cyc > 0) begin
      obs = {a_fall, a_rise, b_fall, b_rise};
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        checks++;
        assert (0) else begin
          failures++;
          $error("FAIL missed_pulse due=%0d observed=none expected=%b",
                 e.due, e.p);
        end
      end
      checks++;
      assert (!(a_fall && a_rise) && !(b_fall && b_rise)) else begin
        failures++;
        $error("FAIL pulse_excl cyc=%0d observed=%b expected=no_fall_rise_pair",
               cyc, obs);
      end
      if (obs !== 4'b0000) begin
        if (q.size() == 0) begin
          checks++;
          assert (0) else begin
            failures++;
            $error("FAIL spurious_pulse cyc=%0d observed=%b expected=0000",
                   cyc, obs);
          end
        end else begin
          e = q.pop_front();
          checks++;
          assert (cyc === e.due) else begin
            failures++;
            $error("FAIL pulse_cycle observed=%0d expected=%0d",
                   cyc, e.due);
          end
          checks++;
          assert (obs === e.p) else begin
            failures++;
            $error("FAIL pulse_kind cyc=%0d observed=%b expected=%b",
                   cyc, obs, e.p);
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst   = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_a", 16'(a), 16'h1);
      chk("rst_b", 16'(b), 16'h1);
      chk("rst_pulses",
          16'({a_fall, a_rise, b_fall, b_rise}), 16'h0);
      chk("rst_cnt", dut.u_a.cnt, 16'h0);
    end
    rst = 1'b0;
    t = cyc;
    push(t + LAT, AF);
    tick();
    chk("rel_a", 16'(a), 16'h1);
    wait_to(t + LAT - 1);
    chk("rel_a_early", 16'(a), 16'h1);
    tick();
    chk("rel_a_fell", 16'(a), 16'h0);
    tick();
    chk("rel_a_hold", 16'(a), 16'h0);

    a_raw = 1'b1;
    t = cyc;
    push(t + LAT, AR);
    wait_to(t + LAT);
    chk("a_back_high", 16'(a), 16'h1);
    wait_to(t + 10);

    a_raw = 1'b0;
    t = cyc;
    push(t + LAT, AF);
    wait_to(t + LAT - 1);
    chk("clean_a_early", 16'(a), 16'h1);
    tick();
    chk("clean_a_fell", 16'(a), 16'h0);
    chk("clean_a_fall", 16'(a_fall), 16'h1);
    tick();
    chk("clean_a_fall_1cyc", 16'(a_fall), 16'h0);
    wait_to(t + 10);
    a_raw = 1'b1;
    t = cyc;
    push(t + LAT, AR);
    wait_to(t + LAT + 4);
    chk("clean_a_rose", 16'(a), 16'h1);

    b_raw = 1'b0;
    t = cyc;
    wait_to(t + 3);
    b_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_b", 16'(b), 16'h1);
    end

    a_raw = 1'b0;
    b_raw = 1'b0;
    t = cyc;
    push(t + LAT, AF | BF);
    wait_to(t + LAT);
    chk("sim_a", 16'(a), 16'h0);
    chk("sim_b", 16'(b), 16'h0);
    wait_to(t + 10);
    a_raw = 1'b1;
    b_raw = 1'b1;
    t = cyc;
    push(t + LAT, AR | BR);
    wait_to(t + LAT + 4);
    chk("sim_ab_high", 16'({a, b}), 16'h3);

    a_raw = 1'b0;
    t = cyc;
    wait_to(t + 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", dut.u_a.cnt, 16'h0);
    chk("mid_rst_a", 16'(a), 16'h1);
    tick();
    chk("mid_rst_cnt2", dut.u_a.cnt, 16'h0);
    rst = 1'b0;
    t = cyc;
    push(t + LAT, AF);
    tick();
    chk("mid_rel_a", 16'(a), 16'h1);
    wait_to(t + LAT - 1);
    chk("mid_a_early", 16'(a), 16'h1);
    tick();
    chk("mid_a_fell", 16'(a), 16'h0);
    wait_to(t + 10);
    a_raw = 1'b1;
    t = cyc;
    push(t + LAT, AR);
    wait_to(t + LAT + 4);

    t = cyc;
    push(t + LAT, AF);
    push(t + 10 + LAT, BF);
    push(t + 20 + LAT, AR);
    push(t + 30 + LAT, BR);
    a_raw = 1'b0;
    wait_to(t + 10);
    b_raw = 1'b0;
    wait_to(t + 20);
    a_raw = 1'b1;
    wait_to(t + 30);
    b_raw = 1'b1;
    wait_to(t + 45);
    chk("car_end", 16'({a, b}), 16'h3);

    chk("queue_empty", 16'(q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
